// File: rtl/ahb_lite_sram_slave_pkg.sv
// Shared AHB-Lite bus types, slave FSM state encoding and helper functions
// for the SRAM slave.
package ahb_lite_sram_slave_pkg;

  localparam int unsigned DATAWIDTH       = 32;
  localparam int unsigned STRB_W          = DATAWIDTH / 8;
  localparam int unsigned MAX_WAIT_STATES = 7;
  localparam int unsigned WAIT_CNT_W      = 3;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE     = 3'd0,
    HSIZE_HALFWORD = 3'd1,
    HSIZE_WORD     = 3'd2,
    HSIZE_WORD2    = 3'd3,
    HSIZE_WORD4    = 3'd4,
    HSIZE_WORD8    = 3'd5,
    HSIZE_WORD16   = 3'd6,
    HSIZE_WORD32   = 3'd7
  } hsize_t;

  typedef enum logic {
    HRESP_OKAY   = 1'b0,
    HRESP_ERROR1 = 1'b1
  } hresp_t;

  typedef enum logic {
    HWRITE_READ  = 1'b0,
    HWRITE_WRITE = 1'b1
  } hwrite_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } slave_state_t;

  // Little-endian byte-lane enables for a legal (size <= WORD, aligned) transfer.
  function automatic logic [STRB_W-1:0] byte_strobe(input hsize_t size, input logic [1:0] off);
    case (size)
      HSIZE_BYTE:     return STRB_W'(4'b0001 << off);
      HSIZE_HALFWORD: return off[1] ? STRB_W'(4'b1100) : STRB_W'(4'b0011);
      default:        return STRB_W'(4'b1111);
    endcase
  endfunction

endpackage

// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite slave-side bus bundle.
// master: drives address/control/write data and the global HREADY.
// slave : returns HRDATA, HREADYOUT and HRESP.
interface ahb_lite_sram_slave_if
  import ahb_lite_sram_slave_pkg::*;
#(
  parameter int unsigned ADDRWIDTH = 32
);

  logic                 HSEL;
  logic [ADDRWIDTH-1:0] HADDR;
  htrans_t              HTRANS;
  hwrite_t              HWRITE;
  hsize_t               HSIZE;
  hburst_t              HBURST;
  logic                 HREADY;
  logic [DATAWIDTH-1:0] HWDATA;
  logic [DATAWIDTH-1:0] HRDATA;
  logic                 HREADYOUT;
  hresp_t               HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HREADY, HWDATA,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HREADY, HWDATA,
    output HRDATA, HREADYOUT, HRESP
  );

endinterface

// File: rtl/ahb_sram_array.sv
// Single-port word-organised SRAM: asynchronous read, synchronous byte-lane write.
// Ports: clk; addr (word index); be (byte write enables); wdata; rdata.
// Contents are never reset.
module ahb_sram_array
  import ahb_lite_sram_slave_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic                 clk,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [STRB_W-1:0]    be,
  input  logic [DATAWIDTH-1:0] wdata,
  output logic [DATAWIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATAWIDTH-1:0] mem [DEPTH];

  // Byte-lane write.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < STRB_W; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: pipelines the address phase into the data phase,
// adds WAIT_STATES stall cycles to OKAY transfers, performs byte-lane writes
// and answers illegal transfers with the two-cycle ERROR response.
// Ports: HCLK; HRESET (synchronous, active high); bus (slave modport:
// HSEL/HADDR/HTRANS/HWRITE/HSIZE/HBURST/HREADY/HWDATA in,
// HRDATA/HREADYOUT/HRESP out).
module ahb_lite_sram_slave
  import ahb_lite_sram_slave_pkg::*;
#(
  parameter int unsigned ADDRWIDTH       = 32,
  parameter int unsigned SLAVE_ADDRWIDTH = 10,
  parameter int unsigned WAIT_STATES     = 0
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  ahb_lite_sram_slave_if.slave bus
);

  if (WAIT_STATES > MAX_WAIT_STATES) begin : g_bad_wait_states
    $error("WAIT_STATES must not exceed MAX_WAIT_STATES");
  end

  slave_state_t                state_q, state_d;
  logic [WAIT_CNT_W-1:0]       cnt_q, cnt_d;
  logic [SLAVE_ADDRWIDTH-1:0]  word_q;
  logic [STRB_W-1:0]           strb_q;
  hwrite_t                     write_q;
  logic                        accept_c;
  logic                        legal_c;
  logic                        hreadyout_c;
  hresp_t                      hresp_c;
  logic [STRB_W-1:0]           be_c;
  logic [DATAWIDTH-1:0]        rdata_c;
  logic                        unused_burst_c;

  // HBURST carries no decode information: every beat supplies its own address.
  assign unused_burst_c = ^bus.HBURST;

  // Address phase is taken only while this slave is itself ready.
  assign accept_c = bus.HSEL && bus.HREADY && hreadyout_c &&
                    (bus.HTRANS == HTRANS_NONSEQ || bus.HTRANS == HTRANS_SEQ);

  assign legal_c = (bus.HSIZE <= HSIZE_WORD) &&
                   !(bus.HSIZE == HSIZE_HALFWORD && bus.HADDR[0]) &&
                   !(bus.HSIZE == HSIZE_WORD && bus.HADDR[1:0] != 2'b00) &&
                   ((bus.HADDR >> (SLAVE_ADDRWIDTH + 2)) == '0);

  // State register.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_DATA;
        else             cnt_d   = cnt_q - WAIT_CNT_W'(1);
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        if (!accept_c) begin
          state_d = S_IDLE;
        end else if (!legal_c) begin
          state_d = S_ERR1;
        end else if (WAIT_STATES > 0) begin
          state_d = S_WAIT;
          cnt_d   = WAIT_CNT_W'(WAIT_STATES - 1);
        end else begin
          state_d = S_DATA;
        end
      end
    endcase
  end

  // Output decode.
  always_comb begin
    hreadyout_c = 1'b1;
    hresp_c     = HRESP_OKAY;
    case (state_q)
      S_WAIT: hreadyout_c = 1'b0;
      S_ERR1: begin
        hreadyout_c = 1'b0;
        hresp_c     = HRESP_ERROR1;
      end
      S_ERR2: hresp_c = HRESP_ERROR1;
      default: ;
    endcase
  end

  // Address-phase capture for the following data phase.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      word_q  <= '0;
      strb_q  <= '0;
      write_q <= HWRITE_READ;
    end else if (accept_c) begin
      word_q  <= bus.HADDR[SLAVE_ADDRWIDTH+1:2];
      strb_q  <= byte_strobe(bus.HSIZE, bus.HADDR[1:0]);
      write_q <= bus.HWRITE;
    end
  end

  // Errored transfers never reach S_DATA, so they can never write.
  assign be_c = (state_q == S_DATA && write_q == HWRITE_WRITE) ? strb_q : '0;

  ahb_sram_array #(
    .ADDR_W (SLAVE_ADDRWIDTH)
  ) u_array (
    .clk   (HCLK),
    .addr  (word_q),
    .be    (be_c),
    .wdata (bus.HWDATA),
    .rdata (rdata_c)
  );

  assign bus.HRDATA    = (state_q == S_DATA) ? rdata_c : '0;
  assign bus.HREADYOUT = hreadyout_c;
  assign bus.HRESP     = hresp_c;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench for ahb_lite_sram_slave: one zero-wait instance and one
// three-wait-state instance share the master stimulus; tgt selects which
// one is addressed and observed.
module tb_ahb_lite_sram_slave;
  import ahb_lite_sram_slave_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel;
  logic [31:0] haddr;
  htrans_t     htrans;
  hwrite_t     hwrite;
  hsize_t      hsize;
  hburst_t     hburst;
  logic [31:0] hwdata;
  logic        stall;
  logic        tgt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ahb_lite_sram_slave_if #(.ADDRWIDTH(32)) b0 ();
  ahb_lite_sram_slave_if #(.ADDRWIDTH(32)) b3 ();

  assign b0.HSEL   = hsel & ~tgt;
  assign b0.HADDR  = haddr;
  assign b0.HTRANS = htrans;
  assign b0.HWRITE = hwrite;
  assign b0.HSIZE  = hsize;
  assign b0.HBURST = hburst;
  assign b0.HWDATA = hwdata;
  assign b0.HREADY = b0.HREADYOUT & ~stall;

  assign b3.HSEL   = hsel & tgt;
  assign b3.HADDR  = haddr;
  assign b3.HTRANS = htrans;
  assign b3.HWRITE = hwrite;
  assign b3.HSIZE  = hsize;
  assign b3.HBURST = hburst;
  assign b3.HWDATA = hwdata;
  assign b3.HREADY = b3.HREADYOUT & ~stall;

  ahb_lite_sram_slave #(.ADDRWIDTH(32), .SLAVE_ADDRWIDTH(10), .WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESET(rst), .bus(b0.slave));
  ahb_lite_sram_slave #(.ADDRWIDTH(32), .SLAVE_ADDRWIDTH(10), .WAIT_STATES(3)) dut3 (
    .HCLK(clk), .HRESET(rst), .bus(b3.slave));

  logic        obs_ready;
  hresp_t      obs_resp;
  logic [31:0] obs_rdata;
  assign obs_ready = tgt ? b3.HREADYOUT : b0.HREADYOUT;
  assign obs_resp  = tgt ? b3.HRESP     : b0.HRESP;
  assign obs_rdata = tgt ? b3.HRDATA    : b0.HRDATA;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_addr(input htrans_t tr, input logic [31:0] a, input hwrite_t wr,
                            input hsize_t sz, input hburst_t bu);
    hsel = 1'b1; htrans = tr; haddr = a; hwrite = wr; hsize = sz; hburst = bu;
  endtask

  task automatic drive_idle();
    hsel = 1'b0; htrans = HTRANS_IDLE; haddr = '0; hwrite = HWRITE_READ;
    hsize = HSIZE_WORD; hburst = HBURST_SINGLE;
  endtask

  // Single NONSEQ transfer; checks stall count and OKAY, returns read data.
  task automatic xfer(input string tag, input logic [31:0] a, input hwrite_t wr,
                      input hsize_t sz, input logic [31:0] wd, input int exp_waits,
                      output logic [31:0] rd);
    int waits;
    drive_addr(HTRANS_NONSEQ, a, wr, sz, HBURST_SINGLE);
    cyc();
    drive_idle();
    hwdata = wd;
    waits = 0;
    #4;
    while (!obs_ready && waits < 16) begin
      waits++;
      cyc();
      #4;
    end
    check({tag, "_waits"}, 32'(waits), 32'(exp_waits));
    check({tag, "_resp"}, 32'(obs_resp), 32'(HRESP_OKAY));
    rd = obs_rdata;
    cyc();
  endtask

  // Illegal transfer: expects ERROR/low then ERROR/high, then idle OKAY.
  task automatic err_xfer(input string tag, input logic [31:0] a, input hwrite_t wr,
                          input hsize_t sz, input logic [31:0] wd);
    drive_addr(HTRANS_NONSEQ, a, wr, sz, HBURST_SINGLE);
    cyc();
    drive_idle();
    hwdata = wd;
    #4;
    check({tag, "_c1_ready"}, 32'(obs_ready), 32'd0);
    check({tag, "_c1_resp"}, 32'(obs_resp), 32'(HRESP_ERROR1));
    cyc();
    #4;
    check({tag, "_c2_ready"}, 32'(obs_ready), 32'd1);
    check({tag, "_c2_resp"}, 32'(obs_resp), 32'(HRESP_ERROR1));
    check({tag, "_c2_rdata"}, obs_rdata, 32'h0);
    cyc();
    #4;
    check({tag, "_after_resp"}, 32'(obs_resp), 32'(HRESP_OKAY));
    cyc();
  endtask

  logic [31:0] rd;
  logic [31:0] burst_exp [4];
  int          burst_cycles;

  initial begin
    rst = 1'b1; stall = 1'b0; tgt = 1'b0; hwdata = '0;
    drive_idle();
    cyc(); cyc();
    #4;
    check("rst_b0_ready", 32'(b0.HREADYOUT), 32'd1);
    check("rst_b0_resp",  32'(b0.HRESP), 32'(HRESP_OKAY));
    check("rst_b0_rdata", b0.HRDATA, 32'h0);
    check("rst_b3_ready", 32'(b3.HREADYOUT), 32'd1);
    check("rst_b3_rdata", b3.HRDATA, 32'h0);
    cyc();
    rst = 1'b0;
    cyc();

    // Zero-wait write then pipelined read of the same word.
    tgt = 1'b0;
    drive_addr(HTRANS_NONSEQ, 32'h10, HWRITE_WRITE, HSIZE_WORD, HBURST_SINGLE);
    cyc();
    drive_addr(HTRANS_NONSEQ, 32'h10, HWRITE_READ, HSIZE_WORD, HBURST_SINGLE);
    hwdata = 32'hDEADBEEF;
    #4;
    check("t1_wr_ready", 32'(obs_ready), 32'd1);
    check("t1_wr_resp", 32'(obs_resp), 32'(HRESP_OKAY));
    cyc();
    drive_idle();
    #4;
    check("t1_rd_ready", 32'(obs_ready), 32'd1);
    check("t1_rd_data", obs_rdata, 32'hDEADBEEF);
    cyc();

    // Byte-lane merges.
    xfer("t2_word", 32'h0, HWRITE_WRITE, HSIZE_WORD, 32'h11223344, 0, rd);
    xfer("t2_byte", 32'h2, HWRITE_WRITE, HSIZE_BYTE, 32'h00AA0000, 0, rd);
    xfer("t2_half", 32'h0, HWRITE_WRITE, HSIZE_HALFWORD, 32'h0000BBCC, 0, rd);
    xfer("t2_rd", 32'h0, HWRITE_READ, HSIZE_WORD, 32'h0, 0, rd);
    check("t2_rd_data", rd, 32'h11AABBCC);
    xfer("t2_b3w", 32'h3, HWRITE_WRITE, HSIZE_BYTE, 32'h77FFFFFF, 0, rd);
    xfer("t2_h2w", 32'h2, HWRITE_WRITE, HSIZE_HALFWORD, 32'h5566FFFF, 0, rd);
    xfer("t2_rd2", 32'h0, HWRITE_READ, HSIZE_WORD, 32'h0, 0, rd);
    check("t2_rd2_data", rd, 32'h5566BBCC);

    // Three wait states: preload then INCR4 read burst.
    tgt = 1'b1;
    burst_exp[0] = 32'hA0A0A0A0; burst_exp[1] = 32'hA1A1A1A1;
    burst_exp[2] = 32'hA2A2A2A2; burst_exp[3] = 32'hA3A3A3A3;
    for (int i = 0; i < 4; i++) begin
      xfer("t3_pre", 32'h20 + 32'(4 * i), HWRITE_WRITE, HSIZE_WORD, burst_exp[i], 3, rd);
    end
    drive_addr(HTRANS_NONSEQ, 32'h20, HWRITE_READ, HSIZE_WORD, HBURST_INCR4);
    cyc();
    burst_cycles = 0;
    for (int b = 0; b < 4; b++) begin
      if (b < 3) drive_addr(HTRANS_SEQ, 32'h20 + 32'(4 * (b + 1)), HWRITE_READ, HSIZE_WORD, HBURST_INCR4);
      else       drive_idle();
      for (int c = 0; c < 4; c++) begin
        #4;
        check($sformatf("t3_b%0d_c%0d_ready", b, c), 32'(obs_ready), (c == 3) ? 32'd1 : 32'd0);
        if (c == 3) check($sformatf("t3_b%0d_data", b), obs_rdata, burst_exp[b]);
        burst_cycles++;
        cyc();
      end
    end
    check("t3_total_cycles", 32'(burst_cycles), 32'd16);

    // Illegal transfers on the waited slave: no wait states, no writes.
    err_xfer("t4_range", 32'h1000, HWRITE_READ, HSIZE_WORD, 32'h0);
    err_xfer("t4_misalign", 32'h22, HWRITE_WRITE, HSIZE_WORD, 32'hBADBADBA);
    err_xfer("t4_size", 32'h24, HWRITE_WRITE, HSIZE_WORD2, 32'hBADBADBA);
    err_xfer("t4_half_odd", 32'h29, HWRITE_WRITE, HSIZE_HALFWORD, 32'hBADBADBA);
    xfer("t4_rd20", 32'h20, HWRITE_READ, HSIZE_WORD, 32'h0, 3, rd);
    check("t4_rd20_data", rd, 32'hA0A0A0A0);
    xfer("t4_rd24", 32'h24, HWRITE_READ, HSIZE_WORD, 32'h0, 3, rd);
    check("t4_rd24_data", rd, 32'hA1A1A1A1);
    xfer("t4_rd28", 32'h28, HWRITE_READ, HSIZE_WORD, 32'h0, 3, rd);
    check("t4_rd28_data", rd, 32'hA2A2A2A2);

    // Address phase while another slave holds HREADY low is ignored.
    tgt = 1'b0;
    xfer("t5_pre", 32'h30, HWRITE_WRITE, HSIZE_WORD, 32'h55555555, 0, rd);
    drive_addr(HTRANS_NONSEQ, 32'h30, HWRITE_WRITE, HSIZE_WORD, HBURST_SINGLE);
    stall = 1'b1;
    cyc();
    stall = 1'b0;
    drive_idle();
    hwdata = 32'hFFFFFFFF;
    #4;
    check("t5_ready", 32'(obs_ready), 32'd1);
    check("t5_resp", 32'(obs_resp), 32'(HRESP_OKAY));
    check("t5_rdata", obs_rdata, 32'h0);
    cyc();
    xfer("t5_rd", 32'h30, HWRITE_READ, HSIZE_WORD, 32'h0, 0, rd);
    check("t5_rd_data", rd, 32'h55555555);

    // Reset during a write's wait states aborts it.
    tgt = 1'b1;
    xfer("t6_pre", 32'h44, HWRITE_WRITE, HSIZE_WORD, 32'h12345678, 3, rd);
    drive_addr(HTRANS_NONSEQ, 32'h44, HWRITE_WRITE, HSIZE_WORD, HBURST_SINGLE);
    cyc();
    drive_idle();
    hwdata = 32'hCAFEF00D;
    #4;
    check("t6_wait_ready", 32'(obs_ready), 32'd0);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #4;
    check("t6_rst_ready", 32'(obs_ready), 32'd1);
    check("t6_rst_resp", 32'(obs_resp), 32'(HRESP_OKAY));
    check("t6_rst_rdata", obs_rdata, 32'h0);
    cyc(); cyc(); cyc();
    xfer("t6_rd", 32'h44, HWRITE_READ, HSIZE_WORD, 32'h0, 3, rd);
    check("t6_rd_data", rd, 32'h12345678);

    // Zero-wait slave keeps its contents across reset.
    tgt = 1'b0;
    xfer("t6_rd0", 32'h10, HWRITE_READ, HSIZE_WORD, 32'h0, 0, rd);
    check("t6_rd0_data", rd, 32'hDEADBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
